// File: rtl/pool_flatten_stream.sv
`default_nettype none
// ============================================================================
// Module      : pool_flatten_stream
// Description : Captures a pooled feature map into a local frame buffer and
//               serialises it channel-major, row-major over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_flatten_stream #(
    parameter  int CH     = 1,
    parameter  int IN_H   = 4,
    parameter  int IN_W   = 4,
    parameter  int INT_W  = 8,
    parameter  int FRAC_W = 16,
    localparam int DW     = INT_W + FRAC_W,
    localparam int N      = CH * IN_H * IN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] in_data [CH][IN_H][IN_W],
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 overflow
);

    localparam int c_CW = (CH   > 1) ? $clog2(CH)   : 1;
    localparam int c_HW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int c_WW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int c_IW = (N    > 1) ? $clog2(N)    : 1;

    localparam logic [c_CW-1:0] c_C_LAST = c_CW'(CH - 1);
    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(IN_H - 1);
    localparam logic [c_WW-1:0] c_W_LAST = c_WW'(IN_W - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]             r_state;
    logic [c_CW-1:0]        r_c;
    logic [c_HW-1:0]        r_h;
    logic [c_WW-1:0]        r_w;
    logic [c_IW-1:0]        r_idx;
    logic signed [DW-1:0]   r_buf [N];
    logic                   r_m_valid;
    logic                   r_m_last;
    logic signed [DW-1:0]   r_m_data;
    logic                   r_overflow;

    logic signed [DW-1:0]   w_in_flat [N];
    logic                   w_hs;
    logic                   w_at_last;
    logic                   w_last_hs;
    logic                   w_capture;
    logic                   w_drop;
    logic                   w_advance;
    logic [0:0]             w_nstate;
    logic [c_CW-1:0]        w_nc;
    logic [c_HW-1:0]        w_nh;
    logic [c_WW-1:0]        w_nw;
    logic [c_IW-1:0]        w_nidx;
    logic signed [DW-1:0]   w_ndata;
    logic                   w_nlast;

    // Linear view of the incoming map in stream order (c outer, w inner).
    for (genvar gc = 0; gc < CH; gc++) begin : g_ch
        for (genvar gh = 0; gh < IN_H; gh++) begin : g_row
            for (genvar gw = 0; gw < IN_W; gw++) begin : g_col
                assign w_in_flat[gc*IN_H*IN_W + gh*IN_W + gw] = in_data[gc][gh][gw];
            end
        end
    end

    assign w_hs      = r_m_valid & m_ready;
    assign w_at_last = (r_c == c_C_LAST) && (r_h == c_H_LAST) && (r_w == c_W_LAST);
    assign w_last_hs = w_hs & w_at_last;
    assign w_capture = valid_in & ((r_state == S_IDLE) | w_last_hs);
    assign w_drop    = valid_in & ~w_capture;
    assign w_advance = w_hs & ~w_at_last;

    always_comb begin
        w_nstate = r_state;
        w_nc     = r_c;
        w_nh     = r_h;
        w_nw     = r_w;
        w_nidx   = r_idx;
        if (w_capture) begin
            w_nstate = S_STREAM;
            w_nc     = '0;
            w_nh     = '0;
            w_nw     = '0;
            w_nidx   = '0;
        end else if (w_advance) begin
            w_nidx = r_idx + c_IW'(1);
            if (r_w == c_W_LAST) begin
                w_nw = '0;
                if (r_h == c_H_LAST) begin
                    w_nh = '0;
                    w_nc = r_c + c_CW'(1);
                end else begin
                    w_nh = r_h + c_HW'(1);
                end
            end else begin
                w_nw = r_w + c_WW'(1);
            end
        end else if (w_last_hs) begin
            w_nstate = S_IDLE;
        end
    end

    // Outputs are precomputed for the next cycle so they leave from flops.
    always_comb begin
        w_ndata = '0;
        if (w_capture) begin
            w_ndata = w_in_flat[0];
        end else if (w_nstate == S_STREAM) begin
            w_ndata = r_buf[w_nidx];
        end
        w_nlast = (w_nstate == S_STREAM) && (w_nc == c_C_LAST) &&
                  (w_nh == c_H_LAST) && (w_nw == c_W_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_c        <= '0;
            r_h        <= '0;
            r_w        <= '0;
            r_idx      <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_c        <= w_nc;
            r_h        <= w_nh;
            r_w        <= w_nw;
            r_idx      <= w_nidx;
            r_m_valid  <= (w_nstate == S_STREAM);
            r_m_last   <= w_nlast;
            r_m_data   <= w_ndata;
            r_overflow <= w_drop;
        end
    end

    // Frame storage is not reset; it is always rewritten before being read.
    always_ff @(posedge clk) begin
        if (!rst && w_capture) begin
            r_buf <= w_in_flat;
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign busy     = (r_state == S_STREAM);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pool_flatten_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_flatten_stream
// Description : Self-checking bench for pool_flatten_stream (2x2x2 map, DW=24).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_flatten_stream;

    localparam int c_CH = 2;
    localparam int c_H  = 2;
    localparam int c_W  = 2;
    localparam int c_N  = c_CH * c_H * c_W;

    logic               clk;
    logic               rst;
    logic               valid_in;
    logic signed [23:0] in_data [c_CH][c_H][c_W];
    logic               m_valid;
    logic               m_ready;
    logic signed [23:0] m_data;
    logic               m_last;
    logic               busy;
    logic               overflow;

    int n_vec = 0;
    int n_err = 0;
    int ovf_cnt = 0;
    bit chk_en = 0;

    logic signed [23:0] mq[$];     // elements still owed to the consumer
    bit                 m_ovf;
    logic [24:0]        hlog[$];   // {last, data} of every handshake seen

    pool_flatten_stream #(
        .CH(c_CH), .IN_H(c_H), .IN_W(c_W), .INT_W(8), .FRAC_W(16)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_data(in_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .overflow(overflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: a frame is accepted whenever nothing is owed after this
    // edge's handshake; anything else is a drop.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            if (mq.size() > 0 && m_ready) void'(mq.pop_front());
            m_ovf = 0;
            if (valid_in) begin
                if (mq.size() == 0) begin
                    for (int c = 0; c < c_CH; c++)
                        for (int h = 0; h < c_H; h++)
                            for (int w = 0; w < c_W; w++)
                                mq.push_back(in_data[c][h][w]);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && m_valid === 1'b1 && m_ready) hlog.push_back({m_last, m_data});
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", {31'd0, m_valid}, {31'd0, mq.size() != 0});
            check("m_data", {8'h00, m_data}, {8'h00, (mq.size() != 0) ? mq[0] : 24'sd0});
            check("m_last", {31'd0, m_last}, {31'd0, mq.size() == 1});
            check("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (overflow === 1'b1) ovf_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        valid_in = 1;
        tick();
        valid_in = 0;
    endtask

    task automatic load_lin(input int base);
        for (int c = 0; c < c_CH; c++)
            for (int h = 0; h < c_H; h++)
                for (int w = 0; w < c_W; w++)
                    in_data[c][h][w] = 24'(base + 16*c + 4*h + w);
    endtask

    task automatic load_const(input int v);
        for (int c = 0; c < c_CH; c++)
            for (int h = 0; h < c_H; h++)
                for (int w = 0; w < c_W; w++)
                    in_data[c][h][w] = 24'(v);
    endtask

    task automatic wait_idle(input bit bp);
        int k = 0;
        while ((busy === 1'b1 || mq.size() != 0) && k < 200) begin
            m_ready = bp ? (k % 3 == 0) : 1'b1;
            tick();
            k++;
        end
        m_ready = 1;
        check("idle_timeout", {31'd0, k < 200}, 32'd1);
    endtask

    task automatic check_seq(input string tag, input int first, input int exp [8]);
        for (int i = 0; i < 8; i++) begin
            if (first + i < hlog.size()) begin
                check($sformatf("%s_data%0d", tag, i), {8'h00, hlog[first+i][23:0]},
                      32'(exp[i]) & 32'h00FF_FFFF);
                check($sformatf("%s_last%0d", tag, i), {31'd0, hlog[first+i][24]},
                      {31'd0, i == 7});
            end
        end
    endtask

    initial begin
        int exp_a [8] = '{0, 1, 4, 5, 16, 17, 20, 21};
        int exp_m [8] = '{-1, -1, -1, -1, -1, -1, -1, -1};
        int exp_b [8] = '{100, 101, 104, 105, 116, 117, 120, 121};

        rst = 1; valid_in = 0; m_ready = 1;
        load_lin(0);
        repeat (2) tick();
        @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {8'h00, m_data}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 0;
        chk_en = 1;
        tick();

        // Single frame, continuous ready; element 0 visible right after capture.
        hlog.delete();
        send();
        @(negedge clk);
        check("lat_valid", {31'd0, m_valid}, 32'd1);
        check("lat_data", {8'h00, m_data}, 32'd0);
        wait_idle(0);
        check("t1_count", hlog.size(), 32'd8);
        check_seq("t1", 0, exp_a);

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        hlog.delete();
        send();
        wait_idle(1);
        check("t2_count", hlog.size(), 32'd8);
        check_seq("t2", 0, exp_a);

        // Back-to-back: second frame presented on the last-handshake cycle.
        hlog.delete();
        ovf_cnt = 0;
        send();
        repeat (7) tick();
        load_const(-1);
        send();
        wait_idle(0);
        check("t3_count", hlog.size(), 32'd16);
        check_seq("t3a", 0, exp_a);
        check_seq("t3b", 8, exp_m);
        check("t3_ovf", ovf_cnt, 32'd0);

        // Drop: a new frame while element 2 is on the bus.
        hlog.delete();
        ovf_cnt = 0;
        load_lin(0);
        send();
        repeat (2) tick();
        load_lin(500);
        send();
        wait_idle(0);
        check("t4_ovf", ovf_cnt, 32'd1);
        check("t4_count", hlog.size(), 32'd8);
        check_seq("t4", 0, exp_a);

        // Reset after element 3 has been handed over.
        load_lin(0);
        send();
        repeat (4) tick();
        rst = 1;
        tick();
        @(negedge clk);
        check("t5_valid", {31'd0, m_valid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_last", {31'd0, m_last}, 32'd0);
        check("t5_data", {8'h00, m_data}, 32'd0);
        rst = 0;
        tick();
        hlog.delete();
        load_lin(100);
        send();
        wait_idle(0);
        check("t5_count", hlog.size(), 32'd8);
        check_seq("t5", 0, exp_b);

        // Signed extremes pass through bit-exact.
        hlog.delete();
        load_const(0);
        in_data[0][0][0] = -24'sd8388608;
        in_data[0][0][1] = 24'sd8388607;
        send();
        wait_idle(0);
        check("t6_count", hlog.size(), 32'd8);
        if (hlog.size() >= 2) begin
            check("t6_min", {8'h00, hlog[0][23:0]}, 32'h0080_0000);
            check("t6_max", {8'h00, hlog[1][23:0]}, 32'h007F_FFFF);
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pool_flatten_stream.md
# pool_flatten_stream

Flatten/serializer stage placed directly downstream of the 2-D max-pooling block. It captures a complete pooled feature map (presented as a parallel array with a one-cycle valid strobe) into a local frame buffer. It then streams the elements out one per cycle over a valid/ready interface in channel-major, row-major order, which the fully-connected layer consumes. Each frame's final element is tagged with a last flag, and frames that arrive while the block is still streaming are dropped and reported.

## Interface
- CH, default 1: number of channels in the pooled map.
- IN_H, default 4: pooled map height (matches the pooling block's output height).
- IN_W, default 4: pooled map width.
- INT_W, default 8: integer bits of the signed fixed-point sample.
- FRAC_W, default 16: fractional bits.
- DW (localparam) = INT_W + FRAC_W; N (localparam) = CH*IN_H*IN_W.

Ports:
- clk  in  1: single clock; all logic on the rising edge.
- rst  in  1: synchronous, active-high reset.
- valid_in  in  1: one-cycle strobe; in_data holds a complete frame.
- in_data  in  signed [DW-1:0] [CH][IN_H][IN_W]: pooled feature map.
- m_valid  out  1: m_data holds a valid element.
- m_ready  in  1: the consumer accepts the element when m_valid && m_ready.
- m_data  out  signed [DW-1:0]: current element, unmodified (no rescaling).
- m_last  out  1: high with the final element (index N-1) of a frame.
- busy  out  1: high while the block is in S_STREAM.
- overflow  out  1: one-cycle pulse when an incoming frame is dropped.

## Operation
- The FSM has two states, S_IDLE and S_STREAM. Counters c, h, w walk the frame; w increments fastest.
- In S_IDLE with valid_in = 1:
  - Copy all of in_data into the frame buffer.
  - Clear c, h and w to 0.
  - Move to S_STREAM.
- In S_STREAM:
  - m_valid = 1, m_data = buf[c][h][w], m_last = (c, h, w) == (CH-1, IN_H-1, IN_W-1).
  - With no handshake, all outputs hold stable.
- On a handshake that is not the last element: advance w; on wrap, w returns to 0 and h advances; on h wrap, h returns to 0 and c advances.
- On the handshake of the last element:
  - If valid_in is high in the same cycle, capture the new frame, clear the counters and stay in S_STREAM. This gives back-to-back frames with no bubble.
  - Otherwise go to S_IDLE.
- valid_in in S_STREAM, other than on the last handshake:
  - The frame is dropped and the buffer is untouched.
  - overflow pulses high in the following cycle.
- The buffer is written only on capture; the upstream block may change in_data freely after the valid_in cycle.
- m_data is forced to 0 whenever m_valid = 0.
- m_valid, m_data and m_last depend only on registered state. There is no combinational path from m_ready or valid_in to any output.

## Timing
- Reset values: m_valid = 0, m_last = 0, m_data = 0, busy = 0, overflow = 0, state = S_IDLE, counters = 0. Buffer contents are not reset.
- rst wins over every other input in the same cycle. Asserted mid-stream, it discards the frame, and m_valid is 0 after that edge.
- Latency: valid_in sampled at edge T makes element 0 visible with m_valid = 1 after edge T.
- With m_ready held high, element k is presented in cycle T+1+k, and m_last is high in cycle T+N.
- Throughput is 1 element per cycle. m_ready low inserts stalls with no loss or duplication.
- busy rises after the capture edge and falls after the edge of the final handshake, unless a back-to-back capture occurs on that handshake.
- overflow is registered: a drop at edge T gives overflow high for exactly cycle T+1. Multiple drops give one pulse each.

## Test plan
- Single frame, continuous m_ready:
  - Setup: CH=2, IN_H=2, IN_W=2, DW=24, in_data[c][h][w] = 16·c + 4·h + w, one valid_in.
  - Required: m_data sequence 0,1,4,5,16,17,20,21 on 8 consecutive cycles; m_last only on 21; busy then drops.
- Backpressure:
  - Stimulus: same frame, m_ready toggling 1,0,0,1,…
  - Required: each element held stable while stalled; exactly 8 handshakes in order; m_last only on the element 21 handshake.
- Back-to-back frames:
  - Stimulus: second frame (all values −1 = 0xFFFFFF) asserted on the last-handshake cycle.
  - Required: the −1 elements follow 21 with no gap; busy stays high; overflow stays 0.
- Drop:
  - Stimulus: valid_in pulsed during element 2 of the stream.
  - Required: overflow high for exactly one cycle; the output sequence is unchanged (0,1,4,5,16,17,20,21).
- Reset mid-stream:
  - Stimulus: rst held for 1 cycle after element 3.
  - Required: next cycle m_valid = 0, busy = 0, m_last = 0, m_data = 0; a new frame then streams from index 0.
- Signed extremes:
  - Stimulus: elements −8388608 and 8388607.
  - Required: both pass through bit-exact.
